// File: rtl/i2s_frame_sched_pkg.sv
// ---------------------------------------------------------------------------
// i2s_frame_sched_pkg
//   Shared types for the I2S frame scheduler and its neighbours: the
//   operating mode and ws state seen from the ws generator/tracker, and the
//   scheduler's own FSM state and error code encodings.
// ---------------------------------------------------------------------------
package i2s_frame_sched_pkg;

  // Operating mode: master/slave transmit/receive.
  typedef enum logic [1:0] {
    M_MT = 2'd0,
    M_MR = 2'd1,
    M_ST = 2'd2,
    M_SR = 2'd3
  } mode_t;

  // Word-select state reported by the ws generator (master) or tracker (slave).
  typedef enum logic [1:0] {
    WS_IDLE = 2'd0,
    WS_L    = 2'd1,
    WS_R    = 2'd2
  } ws_state_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4
  } sched_state_t;

  typedef enum logic [1:0] {
    E_NONE  = 2'd0,
    E_UNDER = 2'd1,
    E_OVER  = 2'd2,
    E_TMO   = 2'd3
  } err_code_t;

  // Transmit modes feed from the TX FIFO; receive modes fill the RX FIFO.
  function automatic logic is_tx(input mode_t m);
    return (m == M_MT) || (m == M_ST);
  endfunction

endpackage

// File: rtl/i2s_sched_wdog.sv
// ---------------------------------------------------------------------------
// i2s_sched_wdog
//   Watchdog counter for the I2S frame scheduler. Only built when
//   I2S_FRAME_SCHED_WDOG_EN is defined; otherwise this file is empty.
//
//   clk      in   serial clock, state changes on negedge
//   rst_     in   asynchronous active-low reset
//   clear    in   restart the count from zero (scheduler state entry)
//   enable   in   count this cycle
//   expired  out  count has reached WDOG_CYC while enabled
// ---------------------------------------------------------------------------
`ifdef I2S_FRAME_SCHED_WDOG_EN
module i2s_sched_wdog #(
  parameter int WDOG_CYC = 1024
) (
  input  logic clk,
  input  logic rst_,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(WDOG_CYC + 1);

  logic [CW-1:0] count_q, count_d;

  // The count equals the number of enabled cycles since entry; expiry fires
  // on the WDOG_CYC-th one so the scheduler reacts on that very edge.
  assign expired = enable && (count_q == CW'(WDOG_CYC - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(negedge clk or negedge rst_) begin
    if (!rst_) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/i2s_frame_sched.sv
// ---------------------------------------------------------------------------
// i2s_frame_sched
//   Runs a programmed burst of I2S frames by driving tran_en/stop into the ws
//   generator/tracker, counts completed frames, detects FIFO underrun and
//   overrun, and reports done/error/progress to the register layer.
//   All state changes on negedge clk to match the ws logic.
//
//   Optional feature: define I2S_FRAME_SCHED_WDOG_EN to build a watchdog
//   (WDOG_CYC cycles) that bounds the time spent in ARM and DRAIN.
//
//   Ports
//     clk, rst_          serial clock, async active-low reset
//     start              1-cycle pulse, begin burst (IDLE/ERR only)
//     abort              level, finish current frame then stop
//     pause              level, freeze serial activity via stop
//     frame_cnt          frames to transfer, sampled on start (0 = no-op)
//     mode, stereo       operating mode and channel format
//     ws_state, ch_last  ws state and last-bit-of-slot pulse
//     Tx_empty, Rx_full  FIFO status
//     tran_en, stop      control to ws generator/tracker
//     busy               not IDLE
//     done_irq, err_irq  1-cycle completion / error pulses
//     err_code           sticky error cause until next start
//     frames_done        completed frames in current/last burst
// ---------------------------------------------------------------------------
module i2s_frame_sched
  import i2s_frame_sched_pkg::*;
#(
  parameter int CNT_W = 16
`ifdef I2S_FRAME_SCHED_WDOG_EN
  , parameter int WDOG_CYC = 1024
`endif
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [CNT_W-1:0] frame_cnt,
  input  mode_t            mode,
  input  logic             stereo,
  input  ws_state_t        ws_state,
  input  logic             ch_last,
  input  logic             Tx_empty,
  input  logic             Rx_full,
  output logic             tran_en,
  output logic             stop,
  output logic             busy,
  output logic             done_irq,
  output logic             err_irq,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] frames_done
);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] frames_done_q, frames_done_d;
  err_code_t        err_code_q, err_code_d;
  logic             tran_en_q, tran_en_d;
  logic             done_irq_q, done_irq_d;
  logic             err_irq_q, err_irq_d;

  logic tx_mode;
  logic fc;
  logic ready;
  logic xrun;
  logic last_fc;
  logic take_fc;
  logic wdog_expired;

  assign tx_mode = is_tx(mode);

  // A frame ends on the last bit of R in stereo, of L in mono.
  assign fc = ch_last && (stereo ? (ws_state == WS_R) : (ws_state == WS_L));

  assign ready = tx_mode ? !Tx_empty : !Rx_full;

  // FIFO starvation/overflow matters only while more frames are still owed;
  // on the final frame completion takes precedence.
  assign xrun = ch_last && (remaining_q > CNT_W'(1)) && (tx_mode ? Tx_empty : Rx_full);

  assign last_fc = fc && (remaining_q == CNT_W'(1));

`ifdef I2S_FRAME_SCHED_WDOG_EN
  i2s_sched_wdog #(
    .WDOG_CYC (WDOG_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst_    (rst_),
    .clear   (state_d != state_q),
    .enable  ((state_q == S_ARM) || (state_q == S_DRAIN)),
    .expired (wdog_expired)
  );
`else
  assign wdog_expired = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(negedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = (frame_cnt != '0) ? S_ARM : S_IDLE;
        end
      end
      S_ARM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (ready) begin
          state_d = S_RUN;
        end else if (wdog_expired) begin
          state_d = S_ERR;
        end
      end
      S_RUN: begin
        if (xrun || abort || last_fc) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // An error recorded in RUN waits here for ws to go idle, then lands in ERR.
        if (ws_state == WS_IDLE) begin
          state_d = (err_code_q == E_NONE) ? S_IDLE : S_ERR;
        end else if (wdog_expired) begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: counters, tran_en, error code and interrupt pulses
  // -------------------------------------------------------------------------
  always_comb begin
    remaining_d   = remaining_q;
    frames_done_d = frames_done_q;
    err_code_d    = err_code_q;
    tran_en_d     = tran_en_q;
    done_irq_d    = 1'b0;
    err_irq_d     = 1'b0;
    take_fc       = 1'b0;

    case (state_q)
      S_IDLE, S_ERR: begin
        tran_en_d = 1'b0;
        if (start) begin
          remaining_d   = frame_cnt;
          frames_done_d = '0;
          err_code_d    = E_NONE;
          done_irq_d    = (frame_cnt == '0);
        end
      end
      S_ARM: begin
        if (!abort) begin
          if (ready) begin
            tran_en_d = 1'b1;
          end else if (wdog_expired) begin
            err_code_d = E_TMO;
            err_irq_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (xrun) begin
          err_code_d = tx_mode ? E_UNDER : E_OVER;
          tran_en_d  = 1'b0;
        end else begin
          take_fc = fc;
          // Drop enable once only the final frame is owed and ws is active,
          // so the generator sees 0 at the final slot boundary. Covers the
          // single-frame burst, where remaining is 1 from the start.
          if (abort || ((remaining_q == CNT_W'(1)) && (ws_state != WS_IDLE))) begin
            tran_en_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        tran_en_d = 1'b0;
        // After an abort the in-flight frame still counts; after an error it does not.
        take_fc = fc && (err_code_q == E_NONE);
        if (ws_state == WS_IDLE) begin
          if (err_code_q == E_NONE) begin
            done_irq_d = 1'b1;
          end else begin
            err_irq_d = 1'b1;
          end
        end else if (wdog_expired) begin
          err_code_d = E_TMO;
          err_irq_d  = 1'b1;
        end
      end
      default: tran_en_d = 1'b0;
    endcase

    if (take_fc) begin
      if (remaining_q != '0) begin
        remaining_d = remaining_q - CNT_W'(1);
      end
      if (frames_done_q != '1) begin
        frames_done_d = frames_done_q + CNT_W'(1);
      end
    end
  end

  always_ff @(negedge clk or negedge rst_) begin
    if (!rst_) begin
      remaining_q   <= '0;
      frames_done_q <= '0;
      err_code_q    <= E_NONE;
      tran_en_q     <= 1'b0;
      done_irq_q    <= 1'b0;
      err_irq_q     <= 1'b0;
    end else begin
      remaining_q   <= remaining_d;
      frames_done_q <= frames_done_d;
      err_code_q    <= err_code_d;
      tran_en_q     <= tran_en_d;
      done_irq_q    <= done_irq_d;
      err_irq_q     <= err_irq_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy = (state_q != S_IDLE);
    stop = pause && ((state_q == S_ARM) || (state_q == S_RUN) || (state_q == S_DRAIN));
  end

  assign tran_en     = tran_en_q;
  assign done_irq    = done_irq_q;
  assign err_irq     = err_irq_q;
  assign err_code    = err_code_q;
  assign frames_done = frames_done_q;

endmodule

// File: tb/tb_i2s_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_i2s_frame_sched
//   Directed bench for i2s_frame_sched. The DUT changes state on negedge clk;
//   the bench samples outputs and then drives inputs on posedge clk.
//   The watchdog scenario is compiled in only with I2S_FRAME_SCHED_WDOG_EN.
// ---------------------------------------------------------------------------
module tb_i2s_frame_sched;
  import i2s_frame_sched_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_ = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             pause = 1'b0;
  logic [CNT_W-1:0] frame_cnt = '0;
  mode_t            mode = M_MT;
  logic             stereo = 1'b1;
  ws_state_t        ws_state = WS_IDLE;
  logic             ch_last = 1'b0;
  logic             Tx_empty = 1'b0;
  logic             Rx_full = 1'b0;
  logic             tran_en, stop, busy, done_irq, err_irq;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] frames_done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  i2s_frame_sched #(
    .CNT_W (CNT_W)
`ifdef I2S_FRAME_SCHED_WDOG_EN
    , .WDOG_CYC (16)
`endif
  ) dut (
    .clk         (clk),
    .rst_        (rst_),
    .start       (start),
    .abort       (abort),
    .pause       (pause),
    .frame_cnt   (frame_cnt),
    .mode        (mode),
    .stereo      (stereo),
    .ws_state    (ws_state),
    .ch_last     (ch_last),
    .Tx_empty    (Tx_empty),
    .Rx_full     (Rx_full),
    .tran_en     (tran_en),
    .stop        (stop),
    .busy        (busy),
    .done_irq    (done_irq),
    .err_irq     (err_irq),
    .err_code    (err_code),
    .frames_done (frames_done)
  );

  always #5 clk = ~clk;

  // Pulse counters so a test can confirm an irq fired exactly once.
  always @(posedge clk) begin
    if (done_irq) done_cnt++;
    if (err_irq)  err_cnt++;
  end

  task automatic step();
    @(posedge clk);
  endtask

  // One ws slot of len cycles; ch_last on the final cycle when last is set.
  task automatic drive_slot(input ws_state_t ws, input int len, input bit last);
    for (int i = 0; i < len; i++) begin
      ws_state = ws;
      ch_last  = last && (i == len - 1);
      step();
    end
    ch_last = 1'b0;
  endtask

  // Start a burst and advance through ARM into RUN (data assumed ready).
  task automatic launch(input mode_t m, input logic st, input int cnt);
    mode      = m;
    stereo    = st;
    frame_cnt = CNT_W'(cnt);
    start     = 1'b1;
    step();
    start     = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_  = 1'b0;
    pause = 1'b1;
    repeat (3) step();
    n_cmp++; if (tran_en !== 1'b0) begin n_bad++; $display("FAIL reset_tran_en: got %b want 0", tran_en); end
    n_cmp++; if (stop !== 1'b0) begin n_bad++; $display("FAIL reset_stop: got %b want 0", stop); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({done_irq, err_irq} !== 2'b00) begin n_bad++; $display("FAIL reset_irqs: got %b want 00", {done_irq, err_irq}); end
    n_cmp++; if (err_code !== 2'd0) begin n_bad++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
    n_cmp++; if (frames_done !== '0) begin n_bad++; $display("FAIL reset_frames_done: got %0d want 0", frames_done); end
    pause = 1'b0;
    rst_  = 1'b1;
    step();
  endtask

  task automatic test_stereo_burst();
    int d0 = done_cnt;
    mode = M_MT; stereo = 1'b1; Tx_empty = 1'b0; frame_cnt = CNT_W'(3);
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if ({busy, tran_en} !== 2'b10) begin n_bad++; $display("FAIL stereo_arm: got busy,tran_en=%b want 10", {busy, tran_en}); end
    step();
    n_cmp++; if (tran_en !== 1'b1) begin n_bad++; $display("FAIL stereo_tran_en_run: got %b want 1", tran_en); end
    drive_slot(WS_L, 4, 1'b1);
    drive_slot(WS_R, 4, 1'b1);
    n_cmp++; if (frames_done !== CNT_W'(1)) begin n_bad++; $display("FAIL stereo_frame1: got %0d want 1", frames_done); end
    // start while busy must be ignored
    ws_state = WS_L; ch_last = 1'b0; frame_cnt = CNT_W'(9); start = 1'b1;
    step();
    start = 1'b0;
    drive_slot(WS_L, 3, 1'b1);
    drive_slot(WS_R, 4, 1'b1);
    n_cmp++; if ({frames_done, tran_en} !== {CNT_W'(2), 1'b1}) begin n_bad++; $display("FAIL stereo_frame2: got frames=%0d tran_en=%b want 2,1", frames_done, tran_en); end
    drive_slot(WS_L, 4, 1'b1);
    n_cmp++; if (tran_en !== 1'b0) begin n_bad++; $display("FAIL stereo_tran_en_frame3: got %b want 0", tran_en); end
    drive_slot(WS_R, 4, 1'b1);
    n_cmp++; if ({frames_done, busy, done_irq} !== {CNT_W'(3), 1'b1, 1'b0}) begin n_bad++; $display("FAIL stereo_drain: got frames=%0d busy=%b done=%b want 3,1,0", frames_done, busy, done_irq); end
    ws_state = WS_IDLE;
    step();
    n_cmp++; if ({done_irq, busy} !== 2'b10) begin n_bad++; $display("FAIL stereo_done: got done,busy=%b want 10", {done_irq, busy}); end
    step();
    n_cmp++; if (done_irq !== 1'b0) begin n_bad++; $display("FAIL stereo_done_pulse: got %b want 0", done_irq); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL stereo_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_mono_single();
    int d0 = done_cnt;
    mode = M_MR; stereo = 1'b0; Rx_full = 1'b0; frame_cnt = CNT_W'(1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_cmp++; if (tran_en !== 1'b1) begin n_bad++; $display("FAIL mono_tran_en_run: got %b want 1", tran_en); end
    step();
    n_cmp++; if (tran_en !== 1'b1) begin n_bad++; $display("FAIL mono_tran_en_ws_idle: got %b want 1", tran_en); end
    ws_state = WS_L;
    step();
    n_cmp++; if (tran_en !== 1'b0) begin n_bad++; $display("FAIL mono_tran_en_drop: got %b want 0", tran_en); end
    drive_slot(WS_L, 3, 1'b1);
    n_cmp++; if ({frames_done, busy} !== {CNT_W'(1), 1'b1}) begin n_bad++; $display("FAIL mono_frames: got frames=%0d busy=%b want 1,1", frames_done, busy); end
    ws_state = WS_IDLE;
    step();
    n_cmp++; if ({done_irq, err_code} !== 3'b100) begin n_bad++; $display("FAIL mono_done: got done=%b err=%0d want 1,0", done_irq, err_code); end
    step();
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL mono_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_zero_cnt();
    frame_cnt = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if ({done_irq, busy, tran_en} !== 3'b100) begin n_bad++; $display("FAIL zero_cnt: got done,busy,tran_en=%b want 100", {done_irq, busy, tran_en}); end
    step();
    n_cmp++; if (done_irq !== 1'b0) begin n_bad++; $display("FAIL zero_cnt_pulse: got %b want 0", done_irq); end
  endtask

  task automatic test_underrun();
    int d0 = done_cnt;
    int e0 = err_cnt;
    Tx_empty = 1'b0;
    launch(M_MT, 1'b1, 5);
    drive_slot(WS_L, 4, 1'b1);
    drive_slot(WS_R, 4, 1'b1);
    n_cmp++; if (frames_done !== CNT_W'(1)) begin n_bad++; $display("FAIL under_frame1: got %0d want 1", frames_done); end
    drive_slot(WS_L, 3, 1'b0);
    ws_state = WS_L; ch_last = 1'b1; Tx_empty = 1'b1;
    step();
    ch_last = 1'b0; Tx_empty = 1'b0;
    n_cmp++; if ({err_code, tran_en, err_irq} !== 4'b0100) begin n_bad++; $display("FAIL under_detect: got err=%0d tran_en=%b err_irq=%b want 1,0,0", err_code, tran_en, err_irq); end
    drive_slot(WS_R, 4, 1'b1);
    n_cmp++; if (frames_done !== CNT_W'(1)) begin n_bad++; $display("FAIL under_frames: got %0d want 1", frames_done); end
    ws_state = WS_IDLE;
    step();
    n_cmp++; if ({err_irq, err_code, busy} !== 4'b1011) begin n_bad++; $display("FAIL under_err_irq: got err_irq=%b err=%0d busy=%b want 1,1,1", err_irq, err_code, busy); end
    step();
    n_cmp++; if ({err_irq, err_code} !== 3'b001) begin n_bad++; $display("FAIL under_sticky: got err_irq=%b err=%0d want 0,1", err_irq, err_code); end
    n_cmp++; if ((err_cnt - e0 != 1) || (done_cnt - d0 != 0)) begin n_bad++; $display("FAIL under_irq_counts: got err=%0d done=%0d want 1,0", err_cnt - e0, done_cnt - d0); end
  endtask

  task automatic test_abort();
    int d0 = done_cnt;
    mode = M_MT; stereo = 1'b1; frame_cnt = CNT_W'(10);
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if ({err_code, busy, frames_done} !== {2'd0, 1'b1, CNT_W'(0)}) begin n_bad++; $display("FAIL abort_restart: got err=%0d busy=%b frames=%0d want 0,1,0", err_code, busy, frames_done); end
    step();
    for (int f = 0; f < 3; f++) begin
      drive_slot(WS_L, 4, 1'b1);
      drive_slot(WS_R, 4, 1'b1);
    end
    n_cmp++; if (frames_done !== CNT_W'(3)) begin n_bad++; $display("FAIL abort_frames3: got %0d want 3", frames_done); end
    drive_slot(WS_L, 4, 1'b1);
    ws_state = WS_R; abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++; if ({tran_en, busy} !== 2'b01) begin n_bad++; $display("FAIL abort_tran_en: got tran_en,busy=%b want 01", {tran_en, busy}); end
    drive_slot(WS_R, 3, 1'b1);
    n_cmp++; if (frames_done !== CNT_W'(4)) begin n_bad++; $display("FAIL abort_frames4: got %0d want 4", frames_done); end
    ws_state = WS_IDLE;
    step();
    n_cmp++; if ({done_irq, err_code} !== 3'b100) begin n_bad++; $display("FAIL abort_done: got done=%b err=%0d want 1,0", done_irq, err_code); end
    step();
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL abort_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_abort_fc();
    launch(M_MT, 1'b1, 3);
    drive_slot(WS_L, 4, 1'b1);
    drive_slot(WS_R, 3, 1'b0);
    ws_state = WS_R; ch_last = 1'b1; abort = 1'b1;
    step();
    ch_last = 1'b0; abort = 1'b0;
    n_cmp++; if ({frames_done, tran_en, busy} !== {CNT_W'(1), 1'b0, 1'b1}) begin n_bad++; $display("FAIL abort_fc: got frames=%0d tran_en=%b busy=%b want 1,0,1", frames_done, tran_en, busy); end
    ws_state = WS_IDLE;
    step();
    n_cmp++; if (done_irq !== 1'b1) begin n_bad++; $display("FAIL abort_fc_done: got %b want 1", done_irq); end
    step();
  endtask

  task automatic test_pause();
    int hits = 0;
    int moved = 0;
    launch(M_MT, 1'b1, 2);
    drive_slot(WS_L, 4, 1'b1);
    n_cmp++; if (stop !== 1'b0) begin n_bad++; $display("FAIL pause_stop_before: got %b want 0", stop); end
    ws_state = WS_R; ch_last = 1'b0; pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (stop === 1'b1) hits++;
      if (frames_done !== '0) moved++;
    end
    pause = 1'b0;
    step();
    n_cmp++; if ((hits != 20) || (stop !== 1'b0)) begin n_bad++; $display("FAIL pause_stop_window: got %0d high, stop after=%b want 20,0", hits, stop); end
    n_cmp++; if ((moved != 0) || (tran_en !== 1'b1)) begin n_bad++; $display("FAIL pause_frozen: got moved=%0d tran_en=%b want 0,1", moved, tran_en); end
    drive_slot(WS_R, 4, 1'b1);
    n_cmp++; if (frames_done !== CNT_W'(1)) begin n_bad++; $display("FAIL pause_frame1: got %0d want 1", frames_done); end
    drive_slot(WS_L, 4, 1'b1);
    drive_slot(WS_R, 4, 1'b1);
    ws_state = WS_IDLE;
    step();
    n_cmp++; if ({done_irq, frames_done} !== {1'b1, CNT_W'(2)}) begin n_bad++; $display("FAIL pause_done: got done=%b frames=%0d want 1,2", done_irq, frames_done); end
    step();
  endtask

`ifdef I2S_FRAME_SCHED_WDOG_EN
  task automatic test_wdog();
    int early = 0;
    mode = M_MT; stereo = 1'b1; Tx_empty = 1'b1; frame_cnt = CNT_W'(2);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      if ((err_irq !== 1'b0) || (busy !== 1'b1) || (err_code !== 2'd0)) early++;
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL wdog_early: got %0d early cycles want 0", early); end
    step();
    n_cmp++; if ({err_irq, err_code, tran_en} !== 4'b1110) begin n_bad++; $display("FAIL wdog_timeout: got err_irq=%b err=%0d tran_en=%b want 1,3,0", err_irq, err_code, tran_en); end
    step();
    n_cmp++; if ({err_irq, busy} !== 2'b01) begin n_bad++; $display("FAIL wdog_err_hold: got err_irq,busy=%b want 01", {err_irq, busy}); end
    Tx_empty = 1'b0;
  endtask
`endif

  task automatic test_reset_midburst();
    Tx_empty = 1'b0;
    launch(M_MT, 1'b1, 4);
    n_cmp++; if (tran_en !== 1'b1) begin n_bad++; $display("FAIL rst_mid_run: got %b want 1", tran_en); end
    drive_slot(WS_L, 2, 1'b0);
    rst_ = 1'b0;
    #1;
    n_cmp++; if ({tran_en, busy, err_code} !== 4'b0000) begin n_bad++; $display("FAIL rst_mid_drop: got tran_en=%b busy=%b err=%0d want 0,0,0", tran_en, busy, err_code); end
    step();
    ws_state = WS_IDLE;
    rst_ = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_stereo_burst();
    test_mono_single();
    test_zero_cnt();
    test_underrun();
    test_abort();
    test_abort_fc();
    test_pause();
`ifdef I2S_FRAME_SCHED_WDOG_EN
    test_wdog();
`endif
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
